// File: rtl/coproc_cmd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// coproc_cmd_pkg : shared constants and FSM state type for the command port
// Rev 1.0
// ----------------------------------------------------------------------------
package coproc_cmd_pkg;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_CLR    = 2'd2;
    localparam logic [1:0] ADDR_CYCLES = 2'd3;

    localparam int CTRL_BUSY = 0;
    localparam int CTRL_DONE = 1;
    localparam int CTRL_TMO  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/coproc_cmd_pio_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// coproc_cmd_pio_if : Avalon-MM slave bus plus coprocessor control lines
// Rev 1.0
// ----------------------------------------------------------------------------
interface coproc_cmd_pio_if #(
    parameter int CMD_W = 32
);
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [CMD_W-1:0] cmd_out;
    logic             start;
    logic             busy;
    logic             done_in;

    modport slave (
        input  address, chipselect, write_n, writedata, done_in,
        output readdata, cmd_out, start, busy
    );

    modport master (
        output address, chipselect, write_n, writedata, done_in,
        input  readdata, cmd_out, start, busy
    );
endinterface
`default_nettype wire

// File: rtl/coproc_cmd_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// coproc_cmd_seq : operation FSM, done edge detect, cycle counter, stickies
// Rev 1.0
// ----------------------------------------------------------------------------
module coproc_cmd_seq
    import coproc_cmd_pkg::*;
#(
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 32
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             i_go,
    input  wire logic             i_clr_done,
    input  wire logic             i_clr_tmo,
    input  wire logic             i_done_in,
    output logic                  o_start,
    output logic                  o_busy,
    output logic                  o_done_sticky,
    output logic                  o_tmo_sticky,
    output logic [CNT_W-1:0]      o_cycles
);

    localparam logic [CNT_W-1:0] c_TMO = CNT_W'(TIMEOUT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_done_q;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done_sticky;
    logic               r_tmo_sticky;
    logic               w_done_edge;
    logic               w_tmo_hit;
    logic               w_set_done;
    logic               w_set_tmo;
    logic               w_cnt_inc;

    assign w_done_edge = i_done_in & ~r_done_q;
    assign w_tmo_hit   = (TIMEOUT != 0) && (r_cnt == c_TMO);

    always_comb begin
        w_state_nxt = r_state;
        w_set_done  = 1'b0;
        w_set_tmo   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_go) w_state_nxt = START;
            end
            START: begin
                w_state_nxt = WAIT;
                w_cnt_inc   = 1'b1;
            end
            WAIT: begin
                // Done outranks a coincident timeout; the count stops at TIMEOUT.
                if (w_done_edge) begin
                    w_state_nxt = IDLE;
                    w_set_done  = 1'b1;
                    w_cnt_inc   = ~w_tmo_hit;
                end else if (w_tmo_hit) begin
                    w_state_nxt = IDLE;
                    w_set_tmo   = 1'b1;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_done_q      <= 1'b0;
            r_cnt         <= '0;
            r_done_sticky <= 1'b0;
            r_tmo_sticky  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_done_q <= i_done_in;

            if (r_state == IDLE && w_state_nxt == START)
                r_cnt <= '0;
            else if (w_cnt_inc && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;

            if (w_set_done)      r_done_sticky <= 1'b1;
            else if (i_clr_done) r_done_sticky <= 1'b0;

            if (w_set_tmo)       r_tmo_sticky  <= 1'b1;
            else if (i_clr_tmo)  r_tmo_sticky  <= 1'b0;
        end
    end

    assign o_start       = (r_state == START);
    assign o_busy        = (r_state != IDLE);
    assign o_done_sticky = r_done_sticky;
    assign o_tmo_sticky  = r_tmo_sticky;
    assign o_cycles      = r_cnt;

endmodule
`default_nettype wire

// File: rtl/coproc_cmd_pio.sv
`default_nettype none
// ----------------------------------------------------------------------------
// coproc_cmd_pio : HPS command port - register decode, CMD register, read mux
// Rev 1.0
// ----------------------------------------------------------------------------
module coproc_cmd_pio
    import coproc_cmd_pkg::*;
#(
    parameter int CMD_W   = 32,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 32
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    coproc_cmd_pio_if.slave     bus
);

    logic               w_wr;
    logic               w_go;
    logic               w_clr_done;
    logic               w_clr_tmo;
    logic               w_busy;
    logic               w_start;
    logic               w_done_sticky;
    logic               w_tmo_sticky;
    logic [CNT_W-1:0]   w_cycles;
    logic [CMD_W-1:0]   r_cmd;
    logic [31:0]        r_readdata;
    logic [31:0]        w_cmd_ext;
    logic [31:0]        w_cyc_ext;
    logic [31:0]        w_rd_nxt;

    assign w_wr       = bus.chipselect & ~bus.write_n;
    assign w_go       = w_wr && (bus.address == ADDR_CTRL) && bus.writedata[0];
    assign w_clr_done = w_wr && (bus.address == ADDR_CLR)  && bus.writedata[1];
    assign w_clr_tmo  = w_wr && (bus.address == ADDR_CLR)  && bus.writedata[2];

    coproc_cmd_seq #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_seq (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_go          (w_go),
        .i_clr_done    (w_clr_done),
        .i_clr_tmo     (w_clr_tmo),
        .i_done_in     (bus.done_in),
        .o_start       (w_start),
        .o_busy        (w_busy),
        .o_done_sticky (w_done_sticky),
        .o_tmo_sticky  (w_tmo_sticky),
        .o_cycles      (w_cycles)
    );

    // Command is frozen for the whole operation; writes while busy are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cmd <= '0;
        else if (w_wr && bus.address == ADDR_CMD && !w_busy)
            r_cmd <= bus.writedata[CMD_W-1:0];
    end

    always_comb begin
        w_cmd_ext              = '0;
        w_cmd_ext[CMD_W-1:0]   = r_cmd;
        w_cyc_ext              = '0;
        w_cyc_ext[CNT_W-1:0]   = w_cycles;
    end

    always_comb begin
        w_rd_nxt = '0;
        case (bus.address)
            ADDR_CMD:    w_rd_nxt = w_cmd_ext;
            ADDR_CTRL: begin
                w_rd_nxt[CTRL_BUSY] = w_busy;
                w_rd_nxt[CTRL_DONE] = w_done_sticky;
                w_rd_nxt[CTRL_TMO]  = w_tmo_sticky;
            end
            ADDR_CLR:    w_rd_nxt = '0;
            ADDR_CYCLES: w_rd_nxt = w_cyc_ext;
            default:     w_rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_readdata <= '0;
        else          r_readdata <= w_rd_nxt;
    end

    assign bus.readdata = r_readdata;
    assign bus.cmd_out  = r_cmd;
    assign bus.start    = w_start;
    assign bus.busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_coproc_cmd_pio.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_coproc_cmd_pio : directed self-checking bench for coproc_cmd_pio
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_coproc_cmd_pio;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;
    int   n_start;
    int   cnt;

    coproc_cmd_pio_if #(.CMD_W(32)) bus ();

    coproc_cmd_pio #(
        .CMD_W   (32),
        .TIMEOUT (20),
        .CNT_W   (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.start) n_start++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write is sampled at the next posedge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    logic [31:0] v;

    initial begin
        n_vec = 0; n_err = 0; n_start = 0;
        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus.done_in    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v);
            chk($sformatf("rst_rd%0d", a), v, 32'h0);
        end
        chk("rst_start", {31'b0, bus.start}, 32'h0);
        chk("rst_busy",  {31'b0, bus.busy},  32'h0);

        // Normal op: CMD=A5, GO, done 10 cycles after start
        wr(2'd0, 32'h0000_00A5);
        n_start = 0;
        wr(2'd1, 32'h1);
        chk("go_start", {31'b0, bus.start}, 32'h1);
        chk("go_busy",  {31'b0, bus.busy},  32'h1);
        chk("go_cmd",   bus.cmd_out, 32'hA5);
        wr(2'd0, 32'h0000_005A);
        wr(2'd1, 32'h1);
        repeat (8) @(negedge clk);
        bus.done_in = 1'b1;
        @(negedge clk);
        chk("done_busy",   {31'b0, bus.busy}, 32'h0);
        chk("busy_cmd",    bus.cmd_out, 32'hA5);
        chk("start_count", n_start, 32'd1);
        rd(2'd1, v); chk("done_ctrl", v, 32'h2);
        rd(2'd3, v); chk("done_cycles", v, 32'd11);
        rd(2'd0, v); chk("cmd_kept", v, 32'hA5);
        bus.done_in = 1'b0;
        @(negedge clk);

        // Timeout op
        wr(2'd2, 32'h2);
        rd(2'd1, v); chk("clr_done", v, 32'h0);
        wr(2'd1, 32'h1);
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_busy_len", cnt, 32'd21);
        rd(2'd1, v); chk("tmo_ctrl", v, 32'h4);
        rd(2'd3, v); chk("tmo_cycles", v, 32'd20);
        wr(2'd2, 32'h4);
        rd(2'd1, v); chk("tmo_clr", v, 32'h0);

        // Done edge coincident with CLR of done
        wr(2'd1, 32'h1);
        repeat (3) @(negedge clk);
        bus.done_in = 1'b1;
        wr(2'd2, 32'h2);
        chk("coinc_busy", {31'b0, bus.busy}, 32'h0);
        rd(2'd1, v); chk("coinc_ctrl", v, 32'h2);
        bus.done_in = 1'b0;
        @(negedge clk);

        // Done edge on the timeout cycle
        wr(2'd2, 32'h6);
        wr(2'd1, 32'h1);
        repeat (20) @(negedge clk);
        chk("edge_tmo_busy_pre", {31'b0, bus.busy}, 32'h1);
        bus.done_in = 1'b1;
        @(negedge clk);
        chk("edge_tmo_busy", {31'b0, bus.busy}, 32'h0);
        rd(2'd1, v); chk("edge_tmo_ctrl", v, 32'h2);
        bus.done_in = 1'b0;
        @(negedge clk);

        // Reset in WAIT, then a late done pulse
        wr(2'd2, 32'h6);
        wr(2'd1, 32'h1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rstw_busy",  {31'b0, bus.busy},  32'h0);
        chk("rstw_start", {31'b0, bus.start}, 32'h0);
        chk("rstw_cmd",   bus.cmd_out, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cnt = 0;
        bus.done_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) bus.done_in = 1'b0;
            if (bus.busy) cnt++;
        end
        chk("rstw_busy_cnt", cnt, 32'd0);
        rd(2'd1, v); chk("rstw_ctrl", v, 32'h0);
        rd(2'd3, v); chk("rstw_cycles", v, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
